seg_scan_controller: RTL and testbench
======================================

Name: seg_scan_controller

Overview:
- Time-multiplexes the shared 7-segment bus (one seg_data bus, one-hot seg_sel) between the NDIG BCD digits of the counter chain.
- Sits between the digit counters (Qdata outputs) and the board display pins; runs on the scan clock domain.
- Takes a frame-coherent snapshot of all digits, applies leading-zero blanking, and inserts a ghosting guard (blank) interval between digit slots.

Parameters:
- NDIG, 4, number of digits scanned (1..SEL_W)
- SEL_W, 6, width of the seg_sel output; bits NDIG..SEL_W-1 are permanently inactive
- SCAN_DIV, 8, clocks per digit slot (>= 2)
- BLANK_CYC, 2, guard cycles at the start of each slot (0 <= BLANK_CYC < SCAN_DIV; 0 means no guard)

Ports:
- clk  in  1  scan clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  scan enable; low forces the display dark
- lz_en  in  1  leading-zero blanking enable
- digits_in  in  4*NDIG  packed BCD, digit i at [4i+3:4i], digit 0 = units
- seg_sel  out  SEL_W  one-hot, active-low digit select
- seg_data  out  7  active-low segments, {g,f,e,d,c,b,a}
- digit_idx  out  clog2(NDIG)  digit currently owning the bus
- frame_start  out  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- All outputs are registered. Reset values: seg_sel all ones, seg_data 7'h7F, digit_idx 0, frame_start 0, state IDLE, snapshot 0, slot counter 0.
- States:
  - IDLE: seg_sel all ones, seg_data 7'h7F.
  - BLANK: seg_sel all ones, seg_data 7'h7F, for BLANK_CYC cycles.
  - SHOW: seg_sel[digit_idx]=0, seg_data=decoded value, for SCAN_DIV-BLANK_CYC cycles.
- Transitions:
  - IDLE -> BLANK (or SHOW if BLANK_CYC=0) on the first clock with en=1. digit_idx is 0.
  - BLANK -> SHOW when the slot counter reaches BLANK_CYC-1.
  - SHOW -> next slot when the slot counter reaches SCAN_DIV-1. The next slot starts in BLANK, or in SHOW if BLANK_CYC=0.
  - digit_idx increments modulo NDIG at each slot boundary; NDIG-1 wraps to 0.
- Frame start:
  - On the first cycle of the digit-0 slot, frame_start=1 and digits_in is captured into the snapshot.
  - The snapshot is the only source for decoding, so digits_in changes mid-frame never reach the display.
  - One frame is NDIG*SCAN_DIV clocks.
- en deasserted (any state): go to IDLE on the next clock; outputs go dark that clock; digit_idx and the slot counter clear. Re-enable restarts at digit 0 with a fresh snapshot.
- rst asserted mid-operation: all outputs take their reset values immediately (asynchronously). After release, behaviour follows the en rules from IDLE.
- Decode:
  - Values 0..9 use the standard active-low patterns: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex).
  - Values A..F display a dash, 7'h3F.
- Leading-zero blanking, when lz_en=1:
  - Digit i (i>0) is blanked if the snapshot digits NDIG-1..i are all zero.
  - A blanked digit still drives seg_sel during SHOW, but seg_data=7'h7F.
  - Digit 0 is never blanked.
  - The blank mask is computed from the snapshot, not from live input.
- Unused select bits: seg_sel[SEL_W-1:NDIG] stay 1 at all times.

Decomposition:
- Shared package (seg_pkg): active-low segment constants SEG_0..SEG_9, SEG_DASH=7'h3F, SEG_OFF=7'h7F; the state encoding (IDLE, BLANK, SHOW).
- One sub-module: bcd_to_7seg, combinational 4-bit BCD in, 7-bit active-low out including the dash for invalid values. The controller instantiates it once, on the muxed snapshot digit.

Test Plan (NDIG=4, SEL_W=6, SCAN_DIV=8, BLANK_CYC=2):
- Timing: rst pulse, en=1, digits_in=16'h1234 -> frame_start every 32 clocks. Each slot is 2 clocks with seg_sel=6'h3F, then 6 clocks with seg_sel=6'h3E/3D/3B/37. seg_data is 7'h19, 30, 24, 79 for digits 0..3.
- Leading zeros: lz_en=1, digits_in=16'h0070 -> digits 3 and 2 show seg_data 7'h7F with select asserted; digit 1 shows 7'h78; digit 0 shows 7'h40. digits_in=16'h0000 -> only digit 0 shows 7'h40. With lz_en=0, all digits show 7'h40.
- Tearing: change digits_in 16'h1234 -> 16'h5678 during the digit-2 SHOW -> digits 2 and 3 still show 24/79. The new values appear only after the next frame_start.
- Invalid BCD: digits_in=16'h00A9 -> digit 1 shows 7'h3F, digit 0 shows 7'h10.
- Enable and reset: drop en during the digit-2 SHOW -> next clock seg_sel=6'h3F, seg_data=7'h7F, digit_idx=0. Assert rst mid-SHOW -> outputs dark without a clock edge. After release with en=1, the scan restarts at digit 0 with a frame_start pulse.
- BLANK_CYC=0 build: SHOW lasts all 8 clocks per slot; seg_sel is never all ones while en=1.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller: active-low segment
// patterns ({g,f,e,d,c,b,a}) and the scan state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes A..F show a dash.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scans NDIG BCD digits onto a shared active-low 7-segment bus with a per-frame
// snapshot, leading-zero blanking and a blank guard interval at each slot start.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int SEL_W     = 6,
  parameter int SCAN_DIV  = 8,
  parameter int BLANK_CYC = 2,
  localparam int IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                lz_en,
  input  logic [4*NDIG-1:0]   digits_in,
  output logic [SEL_W-1:0]    seg_sel,
  output logic [6:0]          seg_data,
  output logic [IDX_W-1:0]    digit_idx,
  output logic                frame_start
);

  // A slot starts in SHOW directly when there is no guard interval.
  localparam scan_state_e SLOT_FIRST = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

  scan_state_e        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [4*NDIG-1:0]  snap_q, snap_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [6:0]         data_q, data_d;
  logic               fs_q, fs_d;
  logic [3:0]         cur_digit;
  logic [6:0]         dec_seg;
  logic [NDIG-1:0]    blank_mask;
  logic               lead_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fs_d    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = SLOT_FIRST;
          cnt_d   = '0;
          idx_d   = '0;
          fs_d    = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (int'(cnt_q) == BLANK_CYC - 1) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (int'(cnt_q) == SCAN_DIV - 1) begin
            cnt_d   = '0;
            state_d = SLOT_FIRST;
            if (int'(idx_q) == NDIG - 1) begin
              idx_d = '0;
              fs_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Snapshot is taken on the same edge that enters the digit-0 slot, so the
  // decode path below already sees the new frame's data.
  assign snap_d = fs_d ? digits_in : snap_q;

  always_comb begin
    cur_digit  = 4'd0;
    blank_mask = '0;
    lead_zero  = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (IDX_W'(i) == idx_d) cur_digit = snap_d[4*i +: 4];
    end
    for (int i = NDIG - 1; i > 0; i--) begin
      lead_zero     = lead_zero && (snap_d[4*i +: 4] == 4'd0);
      blank_mask[i] = lead_zero;
    end
  end

  bcd_to_7seg u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_comb begin
    sel_d  = '1;
    data_d = SEG_OFF;
    if (state_d == ST_SHOW) begin
      sel_d[idx_d] = 1'b0;
      data_d       = (lz_en && blank_mask[idx_d]) ? SEG_OFF : dec_seg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      sel_q   <= '1;
      data_q  <= SEG_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      fs_q    <= fs_d;
    end
  end

  assign seg_sel     = sel_q;
  assign seg_data    = data_q;
  assign digit_idx   = idx_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: a guarded build and a no-guard build share
// stimulus and are checked against a frame/slot arithmetic reference model.
module tb_seg_scan_controller;

  localparam int NDIG     = 4;
  localparam int SEL_W    = 6;
  localparam int SCAN_DIV = 8;
  localparam int FRAME    = NDIG * SCAN_DIV;

  logic             clk;
  logic             rst;
  logic             en;
  logic             lz_en;
  logic [15:0]      digits_in;
  logic [SEL_W-1:0] sel_a, sel_b;
  logic [6:0]       data_a, data_b;
  logic [1:0]       idx_a, idx_b;
  logic             fs_a, fs_b;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          active;
  int          k;
  logic [15:0] snap;
  logic [6:0]  seg_tab [16];

  seg_scan_controller #(.NDIG(NDIG), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .digits_in(digits_in),
    .seg_sel(sel_a), .seg_data(data_a), .digit_idx(idx_a), .frame_start(fs_a)
  );

  seg_scan_controller #(.NDIG(NDIG), .SEL_W(SEL_W), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(0)) u_dut_nb (
    .clk(clk), .rst(rst), .en(en), .lz_en(lz_en), .digits_in(digits_in),
    .seg_sel(sel_b), .seg_data(data_b), .digit_idx(idx_b), .frame_start(fs_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs from frame position k: slot = which digit, off = cycle in slot.
  task automatic expect_out(input int blank, output logic [5:0] sel, output logic [6:0] data,
                            output logic [1:0] idx, output logic fs);
    int  slot, off;
    bit  blanked;
    sel = 6'h3F; data = 7'h7F; idx = 2'd0; fs = 1'b0;
    if (active) begin
      slot = (k / SCAN_DIV) % NDIG;
      off  = k % SCAN_DIV;
      idx  = 2'(slot);
      fs   = (k % FRAME) == 0;
      if (off >= blank) begin
        sel = 6'h3F & ~(6'h01 << slot);
        blanked = lz_en && slot > 0;
        for (int j = slot; j < NDIG; j++) if (((snap >> (4 * j)) & 16'hF) != 0) blanked = 0;
        data = blanked ? 7'h7F : seg_tab[(snap >> (4 * slot)) & 16'hF];
      end
    end
  endtask

  task automatic compare_all(input string where);
    logic [5:0] es;
    logic [6:0] ed;
    logic [1:0] ei;
    logic       ef;
    expect_out(2, es, ed, ei, ef);
    check_eq({where, "/sel"}, 32'(sel_a), 32'(es));
    check_eq({where, "/data"}, 32'(data_a), 32'(ed));
    check_eq({where, "/idx"}, 32'(idx_a), 32'(ei));
    check_eq({where, "/fs"}, 32'(fs_a), 32'(ef));
    expect_out(0, es, ed, ei, ef);
    check_eq({where, "/nb_sel"}, 32'(sel_b), 32'(es));
    check_eq({where, "/nb_data"}, 32'(data_b), 32'(ed));
    check_eq({where, "/nb_idx"}, 32'(idx_b), 32'(ei));
    check_eq({where, "/nb_fs"}, 32'(fs_b), 32'(ef));
  endtask

  // driver: advance one clock, update model with the inputs seen at the edge, compare
  task automatic step(input string where);
    @(posedge clk);
    #1;
    if (rst || !en) begin
      active = 0;
      k = 0;
    end else if (!active) begin
      active = 1;
      k = 0;
    end else begin
      k++;
    end
    if (active && (k % FRAME) == 0) snap = digits_in;
    compare_all(where);
  endtask

  task automatic run(input string where, input int n);
    for (int i = 0; i < n; i++) step(where);
  endtask

  task automatic run_to_pos(input string where, input int pos);
    bit hit = 0;
    for (int i = 0; i < 4 * FRAME && !hit; i++) begin
      step(where);
      if (active && (k % FRAME) == pos) hit = 1;
    end
    check_eq({where, "/reach_pos"}, 32'(hit), 32'd1);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int j = 0; j < 4; j++)
      v[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    active = 0; k = 0; snap = '0;
    rst = 1'b1; en = 1'b0; lz_en = 1'b0; digits_in = 16'h0000;
    #2;
    check_eq("reset/sel", 32'(sel_a), 32'h3F);
    check_eq("reset/data", 32'(data_a), 32'h7F);
    check_eq("reset/idx", 32'(idx_a), 32'd0);
    check_eq("reset/fs", 32'(fs_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run("idle", 3);

    // timing with 1234
    en = 1'b1; digits_in = 16'h1234;
    run("timing", 2 * FRAME + 3);

    // leading zeros
    lz_en = 1'b1; digits_in = 16'h0070;
    run("lz_0070", 2 * FRAME);
    digits_in = 16'h0000;
    run("lz_0000", 2 * FRAME);
    lz_en = 1'b0;
    run("nolz_0000", 2 * FRAME);

    // tearing: switch input during digit-2 SHOW
    digits_in = 16'h1234;
    run_to_pos("tear_pre", 0);
    run_to_pos("tear_pre", 2 * SCAN_DIV + 3);
    digits_in = 16'h5678;
    run("tear", FRAME + 4);

    // invalid BCD
    digits_in = 16'h00A9;
    run("invalid", 2 * FRAME);

    // enable drop during digit-2 SHOW
    run_to_pos("en_pre", 2 * SCAN_DIV + 3);
    en = 1'b0;
    step("en_drop");
    check_eq("en_drop/sel_dark", 32'(sel_a), 32'h3F);
    check_eq("en_drop/idx_zero", 32'(idx_a), 32'd0);
    run("en_off", 3);
    en = 1'b1;
    run("en_back", FRAME + 4);

    // asynchronous reset mid-SHOW
    run_to_pos("rst_pre", 2 * SCAN_DIV + 4);
    #3;
    rst = 1'b1;
    #1;
    check_eq("async_rst/sel", 32'(sel_a), 32'h3F);
    check_eq("async_rst/data", 32'(data_a), 32'h7F);
    check_eq("async_rst/idx", 32'(idx_a), 32'd0);
    check_eq("async_rst/nb_sel", 32'(sel_b), 32'h3F);
    check_eq("async_rst/nb_data", 32'(data_b), 32'h7F);
    active = 0; k = 0;
    @(negedge clk);
    rst = 1'b0;
    step("rst_release");
    check_eq("rst_release/fs", 32'(fs_a), 32'd1);
    run("post_rst", FRAME + 4);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) digits_in = rand_digits();
      if ($urandom_range(0, 39) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 59) == 0) en = 1'b0;
      else if (!en && $urandom_range(0, 3) == 0) en = 1'b1;
      step("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
